i2s_tx_ser: RTL

I2S_TX_SER -- requirements
Module: i2s_tx_ser

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_tx_shreg.sv | 47 ++++
 rtl/i2s_tx_ser.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg
// Shared definitions for the I2S transmit serializer: datapath and counter
// widths, plus the two-state control enum used by i2s_tx_ser.
package i2s_pkg;

  localparam int DATA_W    = 32;
  localparam int BITCNT_W  = 5;
  localparam int WORDCNT_W = 3;

  // IDLE holds everything cleared; RUN serializes words on SCK ticks.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

endpackage

// File: rtl/i2s_tx_shreg.sv
// i2s_tx_shreg
// One serial data lane. A load captures a whole word and drives its first
// bit immediately; each later shift drives the next bit. The bit order is
// chosen by lsb_first, and msb_idx selects the top bit of the active word.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clr           synchronous clear (transmitter disabled)
//   load          capture load_data and drive its first bit
//   shift         drive the next bit of the held word
//   lsb_first     1 = bit 0 first, 0 = bit msb_idx first
//   msb_idx       index of the last bit of a word
//   load_data     word to transmit (zero for an underrun slot)
//   sd            registered serial data output
module i2s_tx_shreg
  import i2s_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic                shift,
  input  logic                lsb_first,
  input  logic [BITCNT_W-1:0] msb_idx,
  input  logic [DATA_W-1:0]   load_data,
  output logic                sd
);

  logic [DATA_W-1:0] sh;

  // The register keeps the bits still to be sent aligned with the output
  // position: MSB-first moves them up towards msb_idx, LSB-first moves them
  // down towards bit 0. Bits above msb_idx are never driven, so unused
  // upper data bits can be left as they came from the FIFO.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sh <= '0;
      sd <= 1'b0;
    end else if (load) begin
      sd <= lsb_first ? load_data[0] : load_data[msb_idx];
      sh <= lsb_first ? (load_data >> 1) : (load_data << 1);
    end else if (shift) begin
      sd <= lsb_first ? sh[0] : sh[msb_idx];
      sh <= lsb_first ? (sh >> 1) : (sh << 1);
    end
  end

endmodule

// File: rtl/i2s_tx_ser.sv
// i2s_tx_ser
// I2S transmit serializer with a two-word prefetch (nxt0 for sd0, nxt1 for
// sd1). Serial outputs and counters advance only on sck_tick_i, the
// one-cycle strobe marking the SCK falling edge. Word select follows the
// Philips timing: ws_o changes one bit ahead of the new half-frame.
// Ports:
//   clk_i, rst_i       clock and synchronous active-high reset
//   sck_tick_i         SCK falling-edge strobe
//   cfg_en_i           transmitter enable; low clears all state
//   cfg_lsb_first_i    1 = LSB first, 0 = MSB first
//   cfg_2ch_i          1 = drive sd0 and sd1, 0 = sd0 only (sd1 held at 0)
//   cfg_bits_word_i    bits per word minus 1
//   cfg_words_i        words per WS half-frame minus 1
//   fifo_data_i        TX word, fifo_valid_i / fifo_ready_o handshake
//   sd0_o, sd1_o       serial data
//   ws_o               word select, 0 = left half-frame
//   underrun_o         one-cycle pulse when a word slot had no data
module i2s_tx_ser
  import i2s_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sck_tick_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_lsb_first_i,
  input  logic                 cfg_2ch_i,
  input  logic [BITCNT_W-1:0]  cfg_bits_word_i,
  input  logic [WORDCNT_W-1:0] cfg_words_i,
  input  logic [DATA_W-1:0]    fifo_data_i,
  input  logic                 fifo_valid_i,
  output logic                 fifo_ready_o,
  output logic                 sd0_o,
  output logic                 sd1_o,
  output logic                 ws_o,
  output logic                 underrun_o
);

  i2s_state_e           state;
  logic [BITCNT_W-1:0]  bit_cnt;
  logic [WORDCNT_W-1:0] word_cnt;
  logic [DATA_W-1:0]    nxt0;
  logic [DATA_W-1:0]    nxt1;
  logic                 full0;
  logic                 full1;

  logic                 run_act;
  logic                 tick_act;
  logic                 boundary;
  logic                 bufs_ready;
  logic                 xfer;
  logic                 under;
  logic                 last_bit;
  logic                 last_word;
  logic                 accept;
  logic                 fill0;
  logic                 fill1;
  logic [DATA_W-1:0]    load0;
  logic [DATA_W-1:0]    load1;

  // bit_cnt is the index of the bit driven by the current tick, so a tick
  // with bit_cnt at 0 is a word boundary; IDLE clears it, which also makes
  // the first tick in RUN a boundary. The >= compare keeps the counters
  // wrapping even if software shrinks the word size mid-word.
  assign run_act    = (state == RUN) && cfg_en_i;
  assign tick_act   = run_act && sck_tick_i;
  assign boundary   = tick_act && (bit_cnt == '0);
  assign bufs_ready = full0 && (!cfg_2ch_i || full1);
  assign xfer       = boundary && bufs_ready;
  assign under      = boundary && !bufs_ready;
  assign last_bit   = (bit_cnt >= cfg_bits_word_i);
  assign last_word  = (word_cnt >= cfg_words_i);

  // A buffer being drained by a transfer this cycle counts as empty, so a
  // word offered on a boundary tick lands in nxt0 while the old nxt0
  // contents go to the shift register. Otherwise nxt0 fills first and nxt1
  // only in two-channel mode.
  assign fifo_ready_o = run_act && !rst_i &&
                        (xfer || !full0 || (cfg_2ch_i && !full1));
  assign accept       = fifo_valid_i && fifo_ready_o;
  assign fill1        = accept && !xfer && full0;
  assign fill0        = accept && !fill1;

  // An underrun slot loads zeros on both lanes; sd1 also gets zeros when
  // only one channel is in use.
  assign load0 = xfer ? nxt0 : '0;
  assign load1 = (xfer && cfg_2ch_i) ? nxt1 : '0;

  // Control, counters, word select and prefetch buffers. Dropping the
  // enable behaves like a reset so that re-enabling starts a clean frame.
  always_ff @(posedge clk_i) begin
    if (rst_i || !cfg_en_i) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      ws_o       <= 1'b0;
      underrun_o <= 1'b0;
      nxt0       <= '0;
      nxt1       <= '0;
      full0      <= 1'b0;
      full1      <= 1'b0;
    end else begin
      state      <= RUN;
      underrun_o <= under;
      if (tick_act) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        if (last_bit) begin
          word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        end
        if (last_bit && last_word) begin
          ws_o <= ~ws_o;
        end
      end
      if (xfer) begin
        full0 <= 1'b0;
        full1 <= 1'b0;
      end
      if (fill0) begin
        nxt0  <= fifo_data_i;
        full0 <= 1'b1;
      end
      if (fill1) begin
        nxt1  <= fifo_data_i;
        full1 <= 1'b1;
      end
    end
  end

  i2s_tx_shreg u_sh0 (
    .clk       (clk_i),
    .rst       (rst_i),
    .clr       (!cfg_en_i),
    .load      (boundary),
    .shift     (tick_act && !boundary),
    .lsb_first (cfg_lsb_first_i),
    .msb_idx   (cfg_bits_word_i),
    .load_data (load0),
    .sd        (sd0_o)
  );

  i2s_tx_shreg u_sh1 (
    .clk       (clk_i),
    .rst       (rst_i),
    .clr       (!cfg_en_i),
    .load      (boundary),
    .shift     (tick_act && !boundary),
    .lsb_first (cfg_lsb_first_i),
    .msb_idx   (cfg_bits_word_i),
    .load_data (load1),
    .sd        (sd1_o)
  );

endmodule
